// File: rtl/oven_setpoint_ctrl.sv
// ---------------------------------------------------------------------------
// oven_setpoint_ctrl
//
// Purpose:
//   Oven front-panel controller. Two active-low keys adjust a temperature
//   setpoint and a cook time. The step size comes from a one-hot step-select
//   switch. Pressing both keys together is a "confirm" that walks the state
//   machine IDLE -> SET_TEMP -> SET_TIME -> COOK -> DONE. While cooking, the
//   remaining time counts down once per TICK_DIV clock cycles, and the heater
//   output is asserted.
//
// Optional feature:
//   OVEN_KEY_REPEAT_EN - when defined, a single key held low auto-repeats.
//   It produces one extra press after REPEAT_DELAY cycles and then one more
//   every REPEAT_RATE cycles. Without the macro, each press produces exactly
//   one step and no repeat counter is built.
//
// Ports:
//   clk            in   single rising-edge clock
//   rst            in   synchronous active-high reset
//   pwr            in   oven power enable; low forces IDLE with defaults
//   key0           in   active-low decrement key
//   key1           in   active-low increment key
//   sw[5:0]        in   step select (one-hot in sw[4:0] with sw[5]=0)
//   target_temp    out  temperature setpoint           (TEMP_W bits, reg)
//   target_time    out  cook time setpoint in seconds  (TIME_W bits, reg)
//   remaining_time out  seconds left in the cook       (TIME_W bits, reg)
//   state          out  IDLE=0 SET_TEMP=1 SET_TIME=2 COOK=3 DONE=4 (reg)
//   heat_on        out  heater enable, high only in COOK (reg)
//   done           out  cook finished flag (reg)
// ---------------------------------------------------------------------------
module oven_setpoint_ctrl #(
    parameter int TEMP_W       = 10,
    parameter int TEMP_MIN     = 65,
    parameter int TEMP_MAX     = 500,
    parameter int TEMP_DEFAULT = 300,
    parameter int TIME_W       = 13,
    parameter int TIME_MAX     = 5999,
    parameter int TICK_DIV     = 50000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwr,
    input  logic              key0,
    input  logic              key1,
    input  logic [5:0]        sw,
    output logic [TEMP_W-1:0] target_temp,
    output logic [TIME_W-1:0] target_time,
    output logic [TIME_W-1:0] remaining_time,
    output logic [2:0]        state,
    output logic              heat_on,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_TEMP = 3'd1,
        SET_TIME = 3'd2,
        COOK     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [TEMP_W-1:0] TEMP_MIN_V = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] TEMP_MAX_V = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0] TEMP_DEF_V = TEMP_W'(TEMP_DEFAULT);
    localparam logic [TIME_W-1:0] TIME_MAX_V = TIME_W'(TIME_MAX);

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Reject nonsensical timing parameters at elaboration time.
    if (TICK_DIV < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("oven_setpoint_ctrl: TICK_DIV, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    // -----------------------------------------------------------------------
    // Step tables and saturating arithmetic
    // -----------------------------------------------------------------------
    function automatic logic [TEMP_W-1:0] temp_step(input logic [5:0] s);
        case (s)
            6'b000001: return TEMP_W'(5);
            6'b000010: return TEMP_W'(10);
            6'b000100: return TEMP_W'(25);
            6'b001000: return TEMP_W'(50);
            6'b010000: return TEMP_W'(100);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [TIME_W-1:0] time_step(input logic [5:0] s);
        case (s)
            6'b000001: return TIME_W'(1);
            6'b000010: return TIME_W'(10);
            6'b000100: return TIME_W'(30);
            6'b001000: return TIME_W'(60);
            6'b010000: return TIME_W'(300);
            default:   return '0;
        endcase
    endfunction

    function automatic logic [TEMP_W-1:0] temp_up(input logic [TEMP_W-1:0] t,
                                                  input logic [TEMP_W-1:0] s);
        logic [TEMP_W:0] sum;
        sum = {1'b0, t} + {1'b0, s};
        if (sum > {1'b0, TEMP_MAX_V}) return TEMP_MAX_V;
        return sum[TEMP_W-1:0];
    endfunction

    function automatic logic [TEMP_W-1:0] temp_down(input logic [TEMP_W-1:0] t,
                                                    input logic [TEMP_W-1:0] s);
        logic signed [TEMP_W:0] diff;
        diff = signed'({1'b0, t}) - signed'({1'b0, s});
        if (diff < signed'({1'b0, TEMP_MIN_V})) return TEMP_MIN_V;
        return diff[TEMP_W-1:0];
    endfunction

    function automatic logic [TIME_W-1:0] time_up(input logic [TIME_W-1:0] t,
                                                  input logic [TIME_W-1:0] s);
        logic [TIME_W:0] sum;
        sum = {1'b0, t} + {1'b0, s};
        if (sum > {1'b0, TIME_MAX_V}) return TIME_MAX_V;
        return sum[TIME_W-1:0];
    endfunction

    function automatic logic [TIME_W-1:0] time_down(input logic [TIME_W-1:0] t,
                                                    input logic [TIME_W-1:0] s);
        logic signed [TIME_W:0] diff;
        diff = signed'({1'b0, t}) - signed'({1'b0, s});
        if (diff < 0) return '0;
        return diff[TIME_W-1:0];
    endfunction

    // -----------------------------------------------------------------------
    // Stage p0: key samples (current and previous), released = 1
    // -----------------------------------------------------------------------
    logic key0_s_p0, key1_s_p0;
    logic key0_d_p0, key1_d_p0;
    logic lock_p0;   // set by a confirm, held until both keys are released

    logic both_low, cfm_ev;
    logic key0_edge, key1_edge;
    logic inc_ev, dec_ev;

    assign both_low  = !key0_s_p0 && !key1_s_p0;
    assign cfm_ev    = both_low && !(!key0_d_p0 && !key1_d_p0);
    assign key0_edge = !key0_s_p0 && key0_d_p0 && key1_s_p0 && !lock_p0;
    assign key1_edge = !key1_s_p0 && key1_d_p0 && key0_s_p0 && !lock_p0;

`ifdef OVEN_KEY_REPEAT_EN
    localparam int RPT_W      = $clog2(REPEAT_DELAY + 1) + 1;
    // After a repeat fires, the count restarts so that the next fire lands
    // exactly REPEAT_RATE samples later.
    localparam int RPT_RELOAD = (REPEAT_RATE >= REPEAT_DELAY) ? 1
                                                              : (REPEAT_DELAY - REPEAT_RATE + 1);

    logic [RPT_W-1:0] rpt_cnt_p0;
    logic             key0_held, key1_held, rpt_fire;

    assign key0_held = !key0_s_p0 && key1_s_p0 && !lock_p0;
    assign key1_held = !key1_s_p0 && key0_s_p0 && !lock_p0;
    assign rpt_fire  = (key0_held || key1_held) && !(key0_edge || key1_edge)
                       && (rpt_cnt_p0 == RPT_W'(REPEAT_DELAY));

    // rpt_cnt equals the number of low samples since the press edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_p0 <= '0;
        end else if (key0_held || key1_held) begin
            if (key0_edge || key1_edge) rpt_cnt_p0 <= RPT_W'(1);
            else if (rpt_fire)          rpt_cnt_p0 <= RPT_W'(RPT_RELOAD);
            else                        rpt_cnt_p0 <= rpt_cnt_p0 + RPT_W'(1);
        end else begin
            rpt_cnt_p0 <= '0;
        end
    end

    assign inc_ev = key1_edge || (rpt_fire && key1_held);
    assign dec_ev = key0_edge || (rpt_fire && key0_held);
`else
    assign inc_ev = key1_edge;
    assign dec_ev = key0_edge;
`endif

    // -----------------------------------------------------------------------
    // Stage p1: registered events with the step values captured alongside
    // -----------------------------------------------------------------------
    logic              inc_vld_p1, dec_vld_p1, cfm_vld_p1;
    logic [TEMP_W-1:0] temp_step_p1;
    logic [TIME_W-1:0] time_step_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            key0_s_p0  <= 1'b1;
            key1_s_p0  <= 1'b1;
            key0_d_p0  <= 1'b1;
            key1_d_p0  <= 1'b1;
            lock_p0    <= 1'b0;
            inc_vld_p1 <= 1'b0;
            dec_vld_p1 <= 1'b0;
            cfm_vld_p1 <= 1'b0;
        end else begin
            key0_s_p0  <= key0;
            key1_s_p0  <= key1;
            key0_d_p0  <= key0_s_p0;
            key1_d_p0  <= key1_s_p0;
            if (cfm_ev)
                lock_p0 <= 1'b1;
            else if (key0_s_p0 && key1_s_p0)
                lock_p0 <= 1'b0;
            inc_vld_p1 <= inc_ev;
            dec_vld_p1 <= dec_ev;
            cfm_vld_p1 <= cfm_ev;
        end
    end

    always_ff @(posedge clk) begin
        temp_step_p1 <= temp_step(sw);
        time_step_p1 <= time_step(sw);
    end

    // -----------------------------------------------------------------------
    // Stage p2: state machine, setpoints, cook timer
    // -----------------------------------------------------------------------
    state_t            fsm;
    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (rst || !pwr) begin
            fsm            <= IDLE;
            target_temp    <= TEMP_DEF_V;
            target_time    <= '0;
            remaining_time <= '0;
            heat_on        <= 1'b0;
            done           <= 1'b0;
            tick_cnt       <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    fsm <= SET_TEMP;
                end
                SET_TEMP: begin
                    if (cfm_vld_p1)
                        fsm <= SET_TIME;
                    else if (inc_vld_p1)
                        target_temp <= temp_up(target_temp, temp_step_p1);
                    else if (dec_vld_p1)
                        target_temp <= temp_down(target_temp, temp_step_p1);
                end
                SET_TIME: begin
                    if (cfm_vld_p1) begin
                        // A zero cook time cannot start; stay and keep editing.
                        if (target_time != '0) begin
                            fsm            <= COOK;
                            remaining_time <= target_time;
                            tick_cnt       <= '0;
                            heat_on        <= 1'b1;
                        end
                    end else if (inc_vld_p1) begin
                        target_time <= time_up(target_time, time_step_p1);
                    end else if (dec_vld_p1) begin
                        target_time <= time_down(target_time, time_step_p1);
                    end
                end
                COOK: begin
                    // Confirm aborts the cook and wins over a tick.
                    if (cfm_vld_p1) begin
                        fsm            <= SET_TEMP;
                        heat_on        <= 1'b0;
                        remaining_time <= '0;
                        tick_cnt       <= '0;
                    end else if (tick_cnt == TICK_LAST) begin
                        tick_cnt <= '0;
                        if (remaining_time <= TIME_W'(1)) begin
                            remaining_time <= '0;
                            fsm            <= DONE;
                            heat_on        <= 1'b0;
                            done           <= 1'b1;
                        end else begin
                            remaining_time <= remaining_time - TIME_W'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                    end
                end
                DONE: begin
                    if (cfm_vld_p1) begin
                        fsm  <= SET_TEMP;
                        done <= 1'b0;
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    heat_on <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    assign state = fsm;

endmodule

// File: tb/tb_oven_setpoint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oven_setpoint_ctrl
//
// Directed bench for oven_setpoint_ctrl with short timing parameters
// (TICK_DIV=4, REPEAT_DELAY=8, REPEAT_RATE=2). Inputs change 1 time unit
// after a rising edge, and outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_oven_setpoint_ctrl;

    localparam int TEMP_W = 10;
    localparam int TIME_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              pwr;
    logic              key0;
    logic              key1;
    logic [5:0]        sw;
    logic [TEMP_W-1:0] target_temp;
    logic [TIME_W-1:0] target_time;
    logic [TIME_W-1:0] remaining_time;
    logic [2:0]        state;
    logic              heat_on;
    logic              done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    oven_setpoint_ctrl #(
        .TICK_DIV    (4),
        .REPEAT_DELAY(8),
        .REPEAT_RATE (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pwr           (pwr),
        .key0          (key0),
        .key1          (key1),
        .sw            (sw),
        .target_temp   (target_temp),
        .target_time   (target_time),
        .remaining_time(remaining_time),
        .state         (state),
        .heat_on       (heat_on),
        .done          (done)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // up=1 presses key1 (increment), up=0 presses key0 (decrement)
    task automatic press(input bit up);
        if (up) key1 = 1'b0;
        else    key0 = 1'b0;
        cyc(2);
        key0 = 1'b1;
        key1 = 1'b1;
        cyc(4);
    endtask

    task automatic confirm();
        key0 = 1'b0;
        key1 = 1'b0;
        cyc(2);
        key0 = 1'b1;
        key1 = 1'b1;
        cyc(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        pwr  = 1'b0;
        key0 = 1'b1;
        key1 = 1'b1;
        sw   = 6'b000000;
        #1;
        cyc(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_temp", 32'(target_temp), 300);
        chk("rst_time", 32'(target_time), 0);
        chk("rst_remain", 32'(remaining_time), 0);
        chk("rst_heat", 32'(heat_on), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;

        // Power on, then coarse temperature steps
        pwr = 1'b1;
        cyc(2);
        chk("pwr_on_state", 32'(state), 1);
        sw = 6'b000100;
        press(1'b1);
        chk("temp_up25_1", 32'(target_temp), 325);
        press(1'b1);
        press(1'b1);
        chk("temp_up25_3", 32'(target_temp), 375);
        sw = 6'b010000;
        for (int i = 0; i < 10; i++) press(1'b0);
        chk("temp_min_sat", 32'(target_temp), 65);

        // Power off from SET_TEMP restores the default setpoint
        pwr = 1'b0;
        cyc(2);
        chk("pwr_off_state", 32'(state), 0);
        chk("pwr_off_temp", 32'(target_temp), 300);
        pwr = 1'b1;
        cyc(2);
        chk("pwr_on2_state", 32'(state), 1);

        // Invalid step selects give a zero step
        sw = 6'b000011;
        press(1'b1);
        chk("sw_two_hot", 32'(target_temp), 300);
        sw = 6'b100001;
        press(1'b1);
        chk("sw_bit5", 32'(target_temp), 300);

        // Upper saturation and a fine decrement
        sw = 6'b010000;
        for (int i = 0; i < 3; i++) press(1'b1);
        chk("temp_max_sat", 32'(target_temp), 500);
        sw = 6'b000001;
        press(1'b0);
        chk("temp_dn5", 32'(target_temp), 495);

        // SET_TIME: a zero time refuses to start the cook
        confirm();
        chk("to_set_time", 32'(state), 2);
        confirm();
        chk("zero_time_stay", 32'(state), 2);
        press(1'b0);
        chk("time_zero_sat", 32'(target_time), 0);
        sw = 6'b010000;
        press(1'b1);
        chk("time_up300", 32'(target_time), 300);
        press(1'b0);
        chk("time_dn300", 32'(target_time), 0);
        sw = 6'b000001;
        for (int i = 0; i < 3; i++) press(1'b1);
        chk("time_set3", 32'(target_time), 3);

        // Start cooking and follow the countdown edge by edge
        key0 = 1'b0;
        key1 = 1'b0;
        cyc(3);
        chk("cook_entry_state", 32'(state), 3);
        chk("cook_entry_heat", 32'(heat_on), 1);
        chk("cook_entry_remain", 32'(remaining_time), 3);
        key0 = 1'b1;
        key1 = 1'b1;
        cyc(3);
        chk("cook_pre_tick", 32'(remaining_time), 3);
        cyc(1);
        chk("cook_tick1", 32'(remaining_time), 2);
        cyc(4);
        chk("cook_tick2", 32'(remaining_time), 1);
        chk("cook_mid_state", 32'(state), 3);
        cyc(4);
        chk("cook_tick3", 32'(remaining_time), 0);
        chk("done_state", 32'(state), 4);
        chk("done_flag", 32'(done), 1);
        chk("done_heat", 32'(heat_on), 0);

        // DONE -> SET_TEMP on confirm
        confirm();
        chk("done_exit_state", 32'(state), 1);
        chk("done_exit_flag", 32'(done), 0);
        chk("done_keep_time", 32'(target_time), 3);

        // Abort a cook with confirm
        confirm();
        confirm();
        chk("cook2_state", 32'(state), 3);
        confirm();
        chk("abort_state", 32'(state), 1);
        chk("abort_heat", 32'(heat_on), 0);
        chk("abort_remain", 32'(remaining_time), 0);
        chk("abort_keep_time", 32'(target_time), 3);
        chk("abort_keep_temp", 32'(target_temp), 495);

        // Power off in the middle of a cook
        confirm();
        confirm();
        chk("cook3_state", 32'(state), 3);
        chk("cook3_heat", 32'(heat_on), 1);
        pwr = 1'b0;
        cyc(2);
        chk("cook_pwr_off_state", 32'(state), 0);
        chk("cook_pwr_off_temp", 32'(target_temp), 300);
        chk("cook_pwr_off_time", 32'(target_time), 0);
        chk("cook_pwr_off_remain", 32'(remaining_time), 0);
        chk("cook_pwr_off_heat", 32'(heat_on), 0);

        // Hold key1 for 14 cycles
        pwr = 1'b1;
        cyc(2);
        chk("pwr_on3_state", 32'(state), 1);
        sw = 6'b000001;
        key1 = 1'b0;
        cyc(14);
        key1 = 1'b1;
        cyc(4);
`ifdef OVEN_KEY_REPEAT_EN
        chk("key_hold_14", 32'(target_temp), 320);
`else
        chk("key_hold_14", 32'(target_temp), 305);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
